// File: rtl/mpsoc_dbg_or1k_access_arb_if.sv
// mpsoc_dbg_or1k_access_arb_if: request/grant and shared-port handshake bundle for the debug access arbiter
interface mpsoc_dbg_or1k_access_arb_if #(
  parameter int NC = 8
);
  localparam int SW = (NC > 1) ? $clog2(NC) : 1;
  logic [NC-1:0] req, stall, gnt, done;
  logic [SW-1:0] sel;
  logic port_stb, port_ack, err, busy;
  modport master(output req, stall, port_ack, input gnt, sel, port_stb, done, err, busy);
  modport slave(input req, stall, port_ack, output gnt, sel, port_stb, done, err, busy);
endinterface

// File: rtl/mpsoc_dbg_or1k_access_arb.sv
// mpsoc_dbg_or1k_access_arb: round-robin sequencer granting the shared debug port to one stalled core at a time
module mpsoc_dbg_or1k_access_arb #(
  parameter int X = 2,
  parameter int Y = 2,
  parameter int Z = 2,
  parameter int CORES_PER_TILE = 1,
  parameter int TIMEOUT = 64
)(
  input logic cpu_clk_i,
  input logic cpu_rstn_i,
  mpsoc_dbg_or1k_access_arb_if.slave bus
);
  localparam int NC = X * Y * Z * CORES_PER_TILE;
  localparam int SW = (NC > 1) ? $clog2(NC) : 1;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [NC-1:0] gnt, elig;
  logic [SW-1:0] sel, ptr, pick, idx;
  logic [CW-1:0] cnt;
  logic err, err_n, found;
  assign elig = bus.req & bus.stall;
  // first eligible core at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int o = 0; o < NC; o++) begin
      idx = SW'((int'(ptr) + o) % NC);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  // ack beats stall drop beats timeout, so err is simply "no ack"
  always_comb begin
    state_n = state;
    err_n = err;
    case (state)
      IDLE: state_n = found ? GRANT : IDLE;
      GRANT: state_n = WAIT;
      WAIT: if (bus.port_ack || !bus.stall[sel] || cnt == CW'(TIMEOUT - 1)) begin
        state_n = DONE;
        err_n = !bus.port_ack;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i)
    if (!cpu_rstn_i) begin
      state <= IDLE;
      err <= 1'b0;
      cnt <= '0;
      ptr <= '0;
      gnt <= '0;
      sel <= '0;
    end else begin
      state <= state_n;
      err <= err_n;
      cnt <= (state == GRANT) ? '0 : (state == WAIT && state_n == WAIT) ? cnt + 1'b1 : cnt;
      if (state == IDLE && found) begin
        gnt <= NC'(1) << pick;
        sel <= pick;
      end
      if (state == DONE) begin
        gnt <= '0;
        sel <= '0;
        ptr <= (sel == SW'(NC - 1)) ? '0 : sel + 1'b1;
      end
    end
  assign bus.gnt = gnt;
  assign bus.sel = sel;
  assign bus.port_stb = state == GRANT;
  assign bus.done = (state == DONE) ? gnt : '0;
  assign bus.err = state == DONE && err;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_mpsoc_dbg_or1k_access_arb.sv
// tb_mpsoc_dbg_or1k_access_arb: directed plus randomized transactions against a round-robin reference model
module tb_mpsoc_dbg_or1k_access_arb;
  localparam int NC = 8;
  localparam int TIMEOUT = 64;
  localparam int NEVER = 1000;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int fails = 0;
  int ptr_m = 0;
  mpsoc_dbg_or1k_access_arb_if #(.NC(NC)) bus();
  mpsoc_dbg_or1k_access_arb #(.X(2), .Y(2), .Z(2), .CORES_PER_TILE(1), .TIMEOUT(TIMEOUT)) dut (
    .cpu_clk_i(clk),
    .cpu_rstn_i(rstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic int model_pick(input logic [NC-1:0] e, input int p);
    for (int o = 0; o < NC; o++)
      if (e[(p + o) % NC]) return (p + o) % NC;
    return -1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_sel"}, 32'(bus.sel), 0);
    chk({tag, "_stb"}, 32'(bus.port_stb), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask
  // one transaction: ack in WAIT cycle ack_at, stall[sel] gone from WAIT cycle drop_at
  task automatic txn(input int ack_at, input int drop_at);
    int exp_c, end_w;
    logic [NC-1:0] g;
    exp_c = model_pick(bus.req & bus.stall, ptr_m);
    g = NC'(1) << exp_c;
    end_w = (ack_at < drop_at) ? ack_at : drop_at;
    if (end_w > TIMEOUT - 1) end_w = TIMEOUT - 1;
    @(negedge clk);
    chk("grant_gnt", 32'(bus.gnt), 32'(g));
    chk("grant_sel", 32'(bus.sel), exp_c);
    chk("grant_stb", 32'(bus.port_stb), 1);
    chk("grant_busy", 32'(bus.busy), 1);
    for (int w = 0; w <= end_w; w++) begin
      @(negedge clk);
      chk("wait_stb", 32'(bus.port_stb), 0);
      chk("wait_done", 32'(bus.done), 0);
      chk("wait_gnt", 32'(bus.gnt), 32'(g));
      bus.req = NC'($urandom);
      bus.stall = NC'($urandom) | g;
      if (w >= drop_at) bus.stall[exp_c] = 1'b0;
      bus.port_ack = (w == ack_at);
    end
    @(negedge clk);
    chk("done_done", 32'(bus.done), 32'(g));
    chk("done_err", 32'(bus.err), 32'(ack_at != end_w));
    chk("done_gnt", 32'(bus.gnt), 32'(g));
    chk("done_busy", 32'(bus.busy), 1);
    bus.port_ack = 1'b0;
    ptr_m = (exp_c + 1) % NC;
    @(negedge clk);
    idle_chk("after");
  endtask
  initial begin
    bus.req = '0;
    bus.stall = '0;
    bus.port_ack = 1'b0;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    rstn = 1'b1;
    @(negedge clk);
    idle_chk("post_reset");
    bus.req = 8'h01;
    bus.stall = 8'h01;
    txn(2, NEVER);
    repeat (9) begin
      bus.req = '1;
      bus.stall = '1;
      txn(0, NEVER);
    end
    bus.req = 8'h04;
    bus.stall = 8'h00;
    repeat (3) begin
      @(negedge clk);
      idle_chk("no_stall");
    end
    bus.stall = 8'h04;
    txn(NEVER, NEVER);
    bus.req = '1;
    bus.stall = '1;
    txn(3, 3);
    bus.req = '1;
    bus.stall = '1;
    txn(NEVER, 2);
    bus.req = '1;
    bus.stall = '1;
    txn(1, 4);
    repeat (40) begin
      bus.req = NC'($urandom);
      bus.stall = NC'($urandom);
      if (model_pick(bus.req & bus.stall, ptr_m) < 0) begin
        @(negedge clk);
        idle_chk("no_elig");
      end else
        txn(($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 6)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : NEVER);
    end
    bus.req = 8'h08;
    bus.stall = 8'h08;
    txn(0, NEVER);
    bus.req = '1;
    bus.stall = '1;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b0;
    #1 idle_chk("async_reset");
    @(negedge clk);
    bus.req = '0;
    bus.stall = '0;
    rstn = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    idle_chk("no_done_after_reset");
    bus.req = '1;
    bus.stall = '1;
    txn(0, NEVER);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end
endmodule
